sram_port_arbiter: RTL

- Shares one local SRAM port between two requesters: port A (core data/instruction side) and port B (wishbone SRAM interface side).
- Both ports and the memory side use the same enable/busy protocol as the local memory bus:
  - A request is held with stable fields until busy is low.
  - Busy low while enabled means the access completes in that cycle.
- Round-robin arbitration with a registered grant. Sits between the requesters and the SRAM macro wrapper.

---
 rtl/sram_arbiter_pkg.sv | 17 +
 rtl/sram_arbiter_rr_select.sv | 26 ++
 rtl/sram_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encodings,
// requester port identifiers and the value read data rests at when idle.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'h0,
    ST_GRANT_A = 2'h1,
    ST_GRANT_B = 2'h2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Read data is replicated from this bit whenever no completion is reported.
  localparam logic RD_IDLE_BIT = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_select.sv
// Round-robin pick between two requesters. On a tie, the port that did not
// win last time is chosen; a single requester always wins.
module sram_arbiter_rr_select
  import sram_arbiter_pkg::*;
(
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_pick
);

  // Combinational pick: tie goes to the port that is not the last winner.
  always_comb begin
    o_valid = i_a_req | i_b_req;
    o_pick  = PORT_A;
    if (i_a_req && i_b_req) begin
      o_pick = ~i_last_grant;
    end else if (i_b_req) begin
      o_pick = PORT_B;
    end else begin
      o_pick = PORT_A;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single local SRAM port.
// Port A is the core side, port B the wishbone side. The grant is registered;
// the memory side is muxed combinationally from the granted port so a
// completion is reported in the same cycle the memory finishes.
// Optional macro SRAM_ARBITER_LOCK_EN adds a_lock/b_lock: a locked completion
// keeps the grant for back-to-back atomic sequences.
module sram_port_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic                      a_enable,
  input  logic                      a_writeEnable,
  input  logic [DATA_WIDTH/8-1:0]   a_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0]  a_address,
  input  logic [DATA_WIDTH-1:0]     a_dataWrite,
  output logic [DATA_WIDTH-1:0]     a_dataRead,
  output logic                      a_busy,
  input  logic                      b_enable,
  input  logic                      b_writeEnable,
  input  logic [DATA_WIDTH/8-1:0]   b_byteSelect,
  input  logic [ADDRESS_WIDTH-1:0]  b_address,
  input  logic [DATA_WIDTH-1:0]     b_dataWrite,
  output logic [DATA_WIDTH-1:0]     b_dataRead,
  output logic                      b_busy,
`ifdef SRAM_ARBITER_LOCK_EN
  input  logic                      a_lock,
  input  logic                      b_lock,
`endif
  output logic                      mem_enable,
  output logic                      mem_writeEnable,
  output logic [DATA_WIDTH/8-1:0]   mem_byteSelect,
  output logic [ADDRESS_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]     mem_dataWrite,
  input  logic [DATA_WIDTH-1:0]     mem_dataRead,
  input  logic                      mem_busy
);

  localparam int BSEL_W = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] RD_IDLE = {DATA_WIDTH{RD_IDLE_BIT}};

  arb_state_t r_state;
  logic       r_last_grant;

  logic w_pick_valid;
  logic w_pick;
  logic w_a_lock;
  logic w_b_lock;
  logic w_a_done;
  logic w_b_done;

`ifdef SRAM_ARBITER_LOCK_EN
  assign w_a_lock = a_lock;
  assign w_b_lock = b_lock;
`else
  assign w_a_lock = 1'b0;
  assign w_b_lock = 1'b0;
`endif

  // A completion needs the grant, a held request and a memory that is not busy.
  assign w_a_done = wb_rst_n_i & (r_state == ST_GRANT_A) & a_enable & ~mem_busy;
  assign w_b_done = wb_rst_n_i & (r_state == ST_GRANT_B) & b_enable & ~mem_busy;

  sram_arbiter_rr_select u_rr_select (
    .i_a_req      (a_enable),
    .i_b_req      (b_enable),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_pick       (w_pick)
  );

  // Grant FSM: arbitrate in IDLE, hold the grant until completion or withdrawal.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_B;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state <= (w_pick == PORT_A) ? ST_GRANT_A : ST_GRANT_B;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT_A: begin
          if (!a_enable) begin
            r_state <= ST_IDLE;
          end else if (!mem_busy && !w_a_lock) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_A;
          end else begin
            r_state <= ST_GRANT_A;
          end
        end
        ST_GRANT_B: begin
          if (!b_enable) begin
            r_state <= ST_IDLE;
          end else if (!mem_busy && !w_b_lock) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_B;
          end else begin
            r_state <= ST_GRANT_B;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side mux and requester responses; everything is quiet during reset.
  always_comb begin
    mem_enable      = 1'b0;
    mem_writeEnable = 1'b0;
    mem_byteSelect  = {BSEL_W{1'b0}};
    mem_address     = {ADDRESS_WIDTH{1'b0}};
    mem_dataWrite   = {DATA_WIDTH{1'b0}};
    a_busy          = a_enable;
    b_busy          = b_enable;
    a_dataRead      = RD_IDLE;
    b_dataRead      = RD_IDLE;
    if (!wb_rst_n_i) begin
      mem_enable = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          a_busy = 1'b1;
          b_busy = 1'b1;
        end
        ST_GRANT_A: begin
          mem_enable      = a_enable;
          mem_writeEnable = a_enable & a_writeEnable;
          mem_address     = a_address;
          if (a_enable && a_writeEnable) begin
            mem_byteSelect = a_byteSelect;
            mem_dataWrite  = a_dataWrite;
          end else begin
            mem_byteSelect = {BSEL_W{1'b0}};
            mem_dataWrite  = {DATA_WIDTH{1'b0}};
          end
          a_busy     = mem_busy;
          a_dataRead = w_a_done ? mem_dataRead : RD_IDLE;
        end
        ST_GRANT_B: begin
          mem_enable      = b_enable;
          mem_writeEnable = b_enable & b_writeEnable;
          mem_address     = b_address;
          if (b_enable && b_writeEnable) begin
            mem_byteSelect = b_byteSelect;
            mem_dataWrite  = b_dataWrite;
          end else begin
            mem_byteSelect = {BSEL_W{1'b0}};
            mem_dataWrite  = {DATA_WIDTH{1'b0}};
          end
          b_busy     = mem_busy;
          b_dataRead = w_b_done ? mem_dataRead : RD_IDLE;
        end
        default: begin
          a_busy = a_enable;
          b_busy = b_enable;
        end
      endcase
    end
  end

endmodule
